exec_sequencer: RTL

//  Parametrised instruction sequencer between the program store (written by the compiler) and the OLED driver.

---
 rtl/exec_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetches instructions from the program store and issues their payloads
// (plus an optional follow-up command) to the OLED driver, with WAIT/END opcodes and abort.
module exec_sequencer #(
    parameter int              OLED_W    = 88,
    parameter int              CMD_W     = 4,
    parameter int              DATA_W    = 96,
    parameter int              ADDR_W    = 3,
    parameter int              RD_LAT    = 1,
    parameter int              DELAY_W   = 24,
    parameter int              FOLLOW_EN = 1,
    parameter logic [7:0]      FOLLOW_OP = 8'h26,
    parameter logic [CMD_W-1:0] WAIT_OP  = 4'hE,
    parameter logic [CMD_W-1:0] END_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              cont,
    input  logic              abort,
    input  logic              rdy_oled,
    input  logic              rdy_compiler,
    input  logic [DATA_W-1:0] DataIn,
    output logic [ADDR_W-1:0] Addr,
    output logic [CMD_W-1:0]  cmd,
    output logic [OLED_W-1:0] oled_IR,
    output logic              draw,
    output logic              busy,
    output logic              done
);
    localparam int IR_W  = OLED_W + CMD_W + 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_GUARD  = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
    localparam logic [2:0] S_DELAY  = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [OLED_W-1:0]  oled_q, oled_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic draw_q, draw_d, done_q, done_d, stop_q, stop_d;
    logic cont_q, cont_d, fs_q, fs_d, run_q;
    logic start, stop;
    logic [CMD_W-1:0]  op;
    logic [OLED_W-1:0] follow;

    assign op     = ir_q[OLED_W+CMD_W-1:OLED_W];
    assign follow = {FOLLOW_OP, 7'b0, ir_q[OLED_W+CMD_W], {(OLED_W-16){1'b0}}};
    assign stop   = stop_q | abort;
    assign start  = run & ~run_q & rdy_compiler & rdy_oled & ~abort;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        oled_d  = oled_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        cont_d  = cont_q;
        fs_d    = fs_q;
        draw_d  = 1'b0;
        done_d  = 1'b0;
        stop_d  = (state_q == S_IDLE) ? 1'b0 : stop;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cont_d  = cont;
                    lat_d   = '0;
                end
            end
            // hold off the capture until the store's read latency has elapsed at this Addr
            S_FETCH: begin
                if (lat_q == LAT_MAX) begin
                    ir_d    = DataIn[IR_W-1:0];
                    state_d = S_DECODE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (op == END_OP) begin
                    addr_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (op == WAIT_OP) begin
                    cnt_d   = ir_q[DELAY_W-1:0];
                    state_d = S_DELAY;
                end else begin
                    oled_d  = ir_q[OLED_W-1:0];
                    draw_d  = 1'b1;
                    fs_d    = 1'b0;
                    state_d = S_GUARD;
                end
            end
            S_GUARD: state_d = S_ACK;
            S_ACK: begin
                if (rdy_oled) begin
                    if (FOLLOW_EN != 0 && !fs_q && !stop) begin
                        oled_d  = follow;
                        draw_d  = 1'b1;
                        fs_d    = 1'b1;
                        state_d = S_GUARD;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_DELAY: begin
                if (stop || cnt_q[DELAY_W-1:1] == '0) state_d = S_NEXT;
                else cnt_d = cnt_q - 1'b1;
            end
            S_NEXT: begin
                addr_d = addr_q + 1'b1;
                if (cont_q && !stop && rdy_compiler) begin
                    state_d = S_FETCH;
                    lat_d   = '0;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            oled_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            draw_q  <= 1'b0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
            cont_q  <= 1'b0;
            fs_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            oled_q  <= oled_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            draw_q  <= draw_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
            cont_q  <= cont_d;
            fs_q    <= fs_d;
            run_q   <= run;
        end
    end

    assign Addr    = addr_q;
    assign cmd     = op;
    assign oled_IR = oled_q;
    assign draw    = draw_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
endmodule
